mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data (MEM-stage) port.
- Sits between the mips core and the unified memory.
- Serialises accesses with a registered request/acknowledge FSM and returns per-port ready pulses that the pipeline uses as stall release.
- Detects a memory that never acknowledges via a watchdog.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses that meet at the memory port arbiter.
//   The bundle covers the fetch port (IReq/IAddr/IRData/IReady) and the data
//   port (DReq/DWe/DAddr/DWData/DRData/DReady) of the pipeline. It also covers
//   the unified memory port (MemReq/MemWe/MemAddr/MemWData/MemRData/MemAck)
//   and the status outputs (BusErr, Owner).
//
// Modports:
//   slave  : the arbiter's view. It takes core requests and memory responses,
//            and drives the ready/read-data outputs and the memory request.
//   master : the surrounding system's view (core + memory), mirrored.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRData;
  logic              IReady;
  // data port
  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic [DATA_W-1:0] DRData;
  logic              DReady;
  // memory port
  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;
  // status
  logic              BusErr;
  logic              Owner;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemAck,
    output IRData, IReady, DRData, DReady,
           MemReq, MemWe, MemAddr, MemWData, BusErr, Owner
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemAck,
    input  IRData, IReady, DRData, DReady,
           MemReq, MemWe, MemAddr, MemWData, BusErr, Owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between the instruction
//   fetch port and the data (MEM-stage) port of the core. Only one access is in
//   flight at a time. The arbiter latches the request into registered Mem*
//   outputs and waits for MemAck. It then returns a one-cycle Ready pulse to the
//   port that owned the access. A watchdog aborts an access that is never
//   acknowledged. The abort returns Ready with BusErr set and zero read data.
//
// Ports:
//   CLK    : clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave. It carries the fetch, data and memory
//            buses plus the BusErr/Owner status.
//
// Parameters:
//   ADDR_W, DATA_W : address / data width
//   TIMEOUT        : number of MemReq cycles without MemAck before an abort
//                    (1..255)
//   MAX_STARVE     : data grants tolerated while a fetch waits. It only has an
//                    effect when the guard is enabled.
//
// Build option:
//   ARB_STARVE_GUARD_EN : define this macro to enable the fetch starvation guard.
//                         When it is undefined, data always wins a tie.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_STARVE = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  // state | meaning
  // ------+---------------------------------------------------------------
  // IDLE  | no access in flight; grant data first, else fetch
  // BUSY  | MemReq high, Mem* held; waiting for MemAck or watchdog expiry
  // DONE  | owner's Ready pulse; one-cycle bubble, never grants
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The watchdog counts BUSY cycles that have already passed without an ack.
  // The abort fires in the TIMEOUT-th BUSY cycle, so MemReq is high for
  // exactly TIMEOUT cycles.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  if (TIMEOUT < 1 || TIMEOUT > 255 || MAX_STARVE < 1) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT must be 1..255 and MAX_STARVE >= 1");
  end

  state_e            state_q, state_d;
  logic [7:0]        wdog_q, wdog_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              owner_q, owner_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              grant_data;
  logic              grant_fetch;
  logic              force_fetch;
  logic              acc_ack;
  logic              acc_timeout;

`ifdef ARB_STARVE_GUARD_EN
  localparam int                  STARVE_W   = $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // A fetch that has waited out MAX_STARVE data grants takes the next slot.
  assign force_fetch = bus.IReq && (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (grant_fetch) begin
      starve_d = '0;
    end else if (grant_data && bus.IReq && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign force_fetch = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      wdog_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d     = state_q;
    wdog_d      = '0;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    acc_ack     = 1'b0;
    acc_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.DReq && !force_fetch) begin
          grant_data = 1'b1;
          state_d    = ST_BUSY;
        end else if (bus.IReq) begin
          grant_fetch = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An ack in the last allowed cycle still completes normally.
        if (bus.MemAck) begin
          acc_ack = 1'b1;
          state_d = ST_DONE;
        end else if (wdog_q == WDOG_LAST) begin
          acc_timeout = 1'b1;
          state_d     = ST_DONE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // registered-output logic
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;

    if (grant_data) begin
      mem_req_d   = 1'b1;
      owner_d     = 1'b1;
      mem_we_d    = bus.DWe;
      mem_addr_d  = bus.DAddr;
      mem_wdata_d = bus.DWData;
    end else if (grant_fetch) begin
      mem_req_d  = 1'b1;
      owner_d    = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = bus.IAddr;
    end

    if (acc_ack || acc_timeout) begin
      mem_req_d = 1'b0;
      bus_err_d = acc_timeout;
      if (owner_q) begin
        d_ready_d = 1'b1;
        d_rdata_d = acc_ack ? bus.MemRData : '0;
      end else begin
        i_ready_d = 1'b1;
        i_rdata_d = acc_ack ? bus.MemRData : '0;
      end
    end
  end

  assign bus.MemReq   = mem_req_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.Owner    = owner_q;
  assign bus.IReady   = i_ready_q;
  assign bus.DReady   = d_ready_q;
  assign bus.BusErr   = bus_err_q;
  assign bus.IRData   = i_rdata_q;
  assign bus.DRData   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives randomized fetch/data requesters and a random-latency memory into
//   mem_port_arbiter. The outputs are compared every cycle against a
//   transaction-level model of the arbitration rules. Directed scenarios pin
//   literal values for reset, fetch-only, tie, long latency, timeout, reset
//   mid-access and the starvation pattern.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int TB_TIMEOUT    = 8;
  localparam int TB_MAX_STARVE = 4;
  localparam int RAND_CYCLES   = 4000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .TIMEOUT   (TB_TIMEOUT),
    .MAX_STARVE(TB_MAX_STARVE)
  ) dut (
    .CLK  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: the access in flight, the completion being reported, and the last
  // data returned to each port
  bit                m_busy;
  bit                m_owner;
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                m_age;
  bit                m_done;
  bit                m_done_owner;
  bit                m_err;
  logic [DATA_W-1:0] m_irdata;
  logic [DATA_W-1:0] m_drdata;
`ifdef ARB_STARVE_GUARD_EN
  int                m_starve;
`endif

  int mem_lat = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_age = 0;
    m_done = 0; m_done_owner = 0; m_err = 0; m_irdata = '0; m_drdata = '0;
`ifdef ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif
  endtask

  task automatic finish_access(input bit err, input logic [DATA_W-1:0] data);
    m_busy       = 0;
    m_done       = 1;
    m_done_owner = m_owner;
    m_err        = err;
    if (m_owner) m_drdata = data;
    else         m_irdata = data;
  endtask

  // Apply the rules to the inputs that the coming rising edge will sample.
  task automatic model_advance();
    bit force_fetch;
    force_fetch = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      m_age++;
      if (bus.MemAck)             finish_access(0, bus.MemRData);
      else if (m_age == TB_TIMEOUT) finish_access(1, '0);
    end else if (m_done) begin
      m_done = 0;
    end else begin
`ifdef ARB_STARVE_GUARD_EN
      force_fetch = bus.IReq && (m_starve == TB_MAX_STARVE);
`endif
      if (bus.DReq && !force_fetch) begin
        m_busy = 1; m_owner = 1; m_age = 0;
        m_we = bus.DWe; m_addr = bus.DAddr; m_wdata = bus.DWData;
`ifdef ARB_STARVE_GUARD_EN
        if (bus.IReq && m_starve < TB_MAX_STARVE) m_starve++;
`endif
      end else if (bus.IReq) begin
        m_busy = 1; m_owner = 0; m_age = 0;
        m_we = 0; m_addr = bus.IAddr;
`ifdef ARB_STARVE_GUARD_EN
        m_starve = 0;
`endif
      end
    end
  endtask

  task automatic compare_outputs();
    check("MemReq", bus.MemReq, m_busy);
    if (m_busy) begin
      check("Owner",   bus.Owner,   m_owner);
      check("MemAddr", bus.MemAddr, m_addr);
      check("MemWe",   bus.MemWe,   m_we);
      if (m_owner) check("MemWData", bus.MemWData, m_wdata);
    end
    check("IReady", bus.IReady, m_done && !m_done_owner);
    check("DReady", bus.DReady, m_done && m_done_owner);
    check("BusErr", bus.BusErr, m_done && m_err);
    check("IRData", bus.IRData, m_irdata);
    check("DRData", bus.DRData, m_drdata);
  endtask

  // Inputs are set at a falling edge; this samples them, then compares at the
  // next falling edge.
  task automatic step();
    model_advance();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    bus.IReq = 0; bus.IAddr = '0;
    bus.DReq = 0; bus.DWe = 0; bus.DAddr = '0; bus.DWData = '0;
    bus.MemAck = 0; bus.MemRData = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = $urandom();
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic drive_random();
    // fetch requester
    if (bus.IReady && bus.IReq) begin
      if ($urandom_range(0, 1) == 0) bus.IReq = 0;
      else bus.IAddr = rand_addr();
    end else if (!bus.IReq) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.IReq = 1; bus.IAddr = rand_addr();
      end
    end else if (m_busy && !m_owner && $urandom_range(0, 31) == 0) begin
      bus.IReq = 0;
    end
    // data requester
    if (bus.DReady && bus.DReq) begin
      if ($urandom_range(0, 1) == 0) bus.DReq = 0;
      else begin
        bus.DAddr = rand_addr(); bus.DWe = 1'($urandom_range(0, 1)); bus.DWData = $urandom();
      end
    end else if (!bus.DReq) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.DReq = 1; bus.DAddr = rand_addr();
        bus.DWe = 1'($urandom_range(0, 1)); bus.DWData = $urandom();
      end
    end else if (m_busy && m_owner && $urandom_range(0, 31) == 0) begin
      bus.DReq = 0;
    end
    // memory: latency L means ack in MemReq cycle L+1; L >= TIMEOUT aborts
    if (bus.MemReq) begin
      if (mem_lat < 0) mem_lat = $urandom_range(0, TB_TIMEOUT + 1);
      bus.MemAck = (mem_lat == 0);
      mem_lat--;
      if (mem_lat < 0) mem_lat = -2;
    end else begin
      mem_lat = -1;
      bus.MemAck = ($urandom_range(0, 7) == 0);
    end
    bus.MemRData = $urandom();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;

    // reset state
    @(negedge clk);
    compare_outputs();
    check("rst_MemReq",  bus.MemReq,  1'b0);
    check("rst_MemAddr", bus.MemAddr, 32'h0);
    check("rst_IReady",  bus.IReady,  1'b0);
    check("rst_DRData",  bus.DRData,  32'h0);
    step();
    rst_n = 1;
    step();

    // fetch only, ack in the first MemReq cycle
    bus.IReq = 1; bus.IAddr = 32'h0000_0040;
    step();
    check("fo_MemReq",  bus.MemReq,  1'b1);
    check("fo_MemAddr", bus.MemAddr, 32'h40);
    check("fo_MemWe",   bus.MemWe,   1'b0);
    bus.MemAck = 1; bus.MemRData = 32'h2008_0005;
    step();
    check("fo_IReady", bus.IReady, 1'b1);
    check("fo_IRData", bus.IRData, 32'h2008_0005);
    bus.IReq = 0; bus.MemAck = 0;
    step();
    check("fo_IReady_pulse", bus.IReady, 1'b0);
    check("fo_idle",         bus.MemReq, 1'b0);

    // tie: data first, fetch once the data access has drained
    bus.IReq = 1; bus.IAddr = 32'h44;
    bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h80; bus.DWData = 32'hCAFE_F00D;
    step();
    check("tie_Owner",    bus.Owner,    1'b1);
    check("tie_MemWe",    bus.MemWe,    1'b1);
    check("tie_MemWData", bus.MemWData, 32'hCAFE_F00D);
    check("tie_MemAddr",  bus.MemAddr,  32'h80);
    bus.MemAck = 1; bus.MemRData = 32'h0BAD_0BAD;
    step();
    check("tie_DReady", bus.DReady, 1'b1);
    bus.DReq = 0; bus.MemAck = 0;
    step();
    check("tie_bubble", bus.MemReq, 1'b0);
    step();
    check("tie_fetch_req",   bus.MemReq, 1'b1);
    check("tie_fetch_owner", bus.Owner,  1'b0);
    bus.MemAck = 1; bus.MemRData = 32'h1111_2222;
    step();
    check("tie_IReady", bus.IReady, 1'b1);
    check("tie_IRData", bus.IRData, 32'h1111_2222);
    bus.IReq = 0; bus.MemAck = 0;
    step();

    // long latency: ack lands in the last cycle before the watchdog would fire
    bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h100;
    step();
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      check("lat_MemReq",  bus.MemReq,  1'b1);
      check("lat_MemAddr", bus.MemAddr, 32'h100);
      check("lat_DReady",  bus.DReady,  1'b0);
      bus.MemAck = (k == TB_TIMEOUT);
      bus.MemRData = 32'hA5A5_0008;
      step();
    end
    check("lat_DReady_done", bus.DReady, 1'b1);
    check("lat_BusErr",      bus.BusErr, 1'b0);
    check("lat_DRData",      bus.DRData, 32'hA5A5_0008);
    bus.MemAck = 0;
    step();
    check("lat_no_regrant", bus.MemReq, 1'b0);
    check("lat_once",       bus.DReady, 1'b0);
    bus.DReq = 0;
    step();

    // timeout: never acknowledged, then a late ack
    bus.DReq = 1; bus.DWe = 1; bus.DAddr = 32'h200; bus.DWData = 32'h1234;
    step();
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      check("to_MemReq", bus.MemReq, 1'b1);
      step();
    end
    check("to_MemReq_drop", bus.MemReq, 1'b0);
    check("to_DReady",      bus.DReady, 1'b1);
    check("to_BusErr",      bus.BusErr, 1'b1);
    check("to_DRData",      bus.DRData, 32'h0);
    bus.DReq = 0; bus.MemAck = 1;
    step();
    check("to_late_ack_req",   bus.MemReq, 1'b0);
    check("to_late_ack_ready", bus.DReady, 1'b0);
    step();
    check("to_late_ack_berr", bus.BusErr, 1'b0);
    bus.MemAck = 0;

    // reset in the middle of an access
    bus.IReq = 1; bus.IAddr = 32'h300;
    step();
    step();
    check("rm_busy", bus.MemReq, 1'b1);
    rst_n = 0;
    #1;
    check("rm_async_drop", bus.MemReq, 1'b0);
    model_reset();
    bus.IReq = 0; bus.MemAck = 1;
    step();
    rst_n = 1;
    step();
    check("rm_no_ready", bus.IReady, 1'b0);
    step();
    bus.MemAck = 0; bus.IReq = 1; bus.IAddr = 32'h304;
    step();
    check("rm_next_addr", bus.MemAddr, 32'h304);
    bus.MemAck = 1; bus.MemRData = 32'h0000_BEEF;
    step();
    check("rm_next_ready", bus.IReady, 1'b1);
    check("rm_next_data",  bus.IRData, 32'h0000_BEEF);
    bus.IReq = 0; bus.MemAck = 0;
    step();

    // both ports held high continuously
    bus.IReq = 1; bus.IAddr = 32'h500;
    bus.DReq = 1; bus.DWe = 0; bus.DAddr = 32'h600;
    begin : starve_blk
      int  owners[$];
      bit  prev_req;
      int  budget;
      int  exp_owner;
      prev_req = 0;
      budget   = 0;
      while (owners.size() < 10 && budget < 80) begin
        bus.MemAck = bus.MemReq;
        bus.MemRData = $urandom();
        step();
        budget++;
        if (bus.MemReq && !prev_req) owners.push_back(int'(bus.Owner));
        prev_req = bus.MemReq;
      end
      check("starve_grants", 64'(owners.size()), 64'd10);
      for (int i = 0; i < owners.size(); i++) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_owner = ((i % (TB_MAX_STARVE + 1)) == TB_MAX_STARVE) ? 0 : 1;
`else
        exp_owner = 1;
`endif
        check($sformatf("starve_owner_%0d", i), 64'(owners[i]), 64'(exp_owner));
      end
    end
    idle_inputs();
    step();
    step();
    step();

    // randomized traffic
    for (int c = 0; c < RAND_CYCLES; c++) begin
      drive_random();
      step();
    end

    idle_inputs();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
